vctr_framer: RTL

- Upstream stage of the vector channel demultiplexer. Builds the serial byte stream on `vctr_data_out`, which the demux splits into three channels by marker byte.
- Frame layout is fixed at three 20-byte slots. Each slot is a marker byte (0x00, 0x01 or 0x02 for ch0, ch1, ch2) followed by 19 payload bytes.
- Payload bytes come from a valid/ready input stream through a 4-deep FIFO. Each output byte is held for one byte period.

---
 rtl/vctr_framer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vctr_framer.sv
// Framer feeding the vector channel demux: three 20-byte slots per frame,
// each a channel marker followed by payload drawn from a 4-deep input FIFO.
module vctr_framer #(
   parameter int unsigned BYTE_CLKS = 1252,
   parameter int unsigned SLOT_LEN  = 20,
   parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] vctr_data_out,
   output logic       byte_strobe,
   output logic       frame_start,
   output logic [7:0] underrun_cnt,
   output logic       busy
);

   localparam int unsigned TW = (BYTE_CLKS > 1) ? $clog2(BYTE_CLKS) : 1;
   localparam int unsigned SW = $clog2(SLOT_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      MARKER,
      PAYLOAD
   } state_t;

   state_t          state;
   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   slot_cnt;
   logic [1:0]      channel;

   logic [7:0]      mem [4];
   logic [1:0]      wr_ptr;
   logic [1:0]      rd_ptr;
   logic [2:0]      count;

   logic            tick;
   logic            slot_done;
   logic            pay_tick;
   logic            push;
   logic            pop;
   logic [7:0]      head;

   assign tick      = (tick_cnt == TW'(BYTE_CLKS - 1));
   assign slot_done = (slot_cnt == SW'(SLOT_LEN));
   assign pay_tick  = tick && (state != IDLE) && !slot_done;
   assign in_ready  = (count != 3'd4);
   assign push      = in_valid && in_ready;
   assign pop       = pay_tick && (count != 3'd0);
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // slot_cnt counts bytes already driven in the current slot (marker = 1),
   // so a slot is finished once it reaches SLOT_LEN.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         slot_cnt      <= '0;
         channel       <= '0;
         vctr_data_out <= FILL_BYTE;
         byte_strobe   <= 1'b0;
         frame_start   <= 1'b0;
         underrun_cnt  <= '0;
      end else begin
         byte_strobe <= 1'b0;
         frame_start <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (enable) begin
                     state         <= MARKER;
                     channel       <= '0;
                     slot_cnt      <= SW'(1);
                     vctr_data_out <= 8'h00;
                     byte_strobe   <= 1'b1;
                     frame_start   <= 1'b1;
                  end
               end
               MARKER, PAYLOAD: begin
                  byte_strobe <= 1'b1;
                  if (!slot_done) begin
                     state    <= PAYLOAD;
                     slot_cnt <= slot_cnt + SW'(1);
                     if (count != 3'd0) begin
                        vctr_data_out <= (head < 8'h03) ? 8'h03 : head;
                     end else begin
                        vctr_data_out <= FILL_BYTE;
                        if (underrun_cnt != 8'hFF) begin
                           underrun_cnt <= underrun_cnt + 8'd1;
                        end
                     end
                  end else if (channel != 2'd2) begin
                     state         <= MARKER;
                     channel       <= channel + 2'd1;
                     slot_cnt      <= SW'(1);
                     vctr_data_out <= {6'b0, channel + 2'd1};
                  end else if (enable) begin
                     state         <= MARKER;
                     channel       <= '0;
                     slot_cnt      <= SW'(1);
                     vctr_data_out <= 8'h00;
                     frame_start   <= 1'b1;
                  end else begin
                     state         <= IDLE;
                     channel       <= '0;
                     slot_cnt      <= '0;
                     vctr_data_out <= FILL_BYTE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
